// File: rtl/param_spine_router.sv
// Spine router: one local NI port plus NUM_SPINES spine ports, each with an input FIFO,
// per-output round-robin arbitration and a one-flit output register.
module param_spine_router #(
  parameter int         DWIDTH     = 16,
  parameter int         NUM_SPINES = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] ROUTER_ID  = 2'd3,
  parameter logic [3:0] GROUP_ID   = 4'b0110
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arb_enable,
  input  logic [DWIDTH-1:0]            gpu_in_data,
  input  logic                         gpu_in_valid,
  output logic                         gpu_in_ready,
  output logic [DWIDTH-1:0]            gpu_out_data,
  output logic                         gpu_out_valid,
  input  logic                         gpu_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [NUM_SPINES:0]          fifo_full,
  output logic [NUM_SPINES:0]          fifo_empty,
  output logic [7:0]                   drop_count
);

  localparam int         P         = NUM_SPINES + 1;
  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         PW        = $clog2(P);
  localparam logic [5:0] SELF_ADDR = {GROUP_ID, ROUTER_ID};

  function automatic logic [5:0] dest_of(input logic [DWIDTH-1:0] f);
    return f[DWIDTH-1 -: 6];
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic int rr_idx(input logic [PW-1:0] last, input int k);
    return (int'(last) + k) % P;
  endfunction

  logic [DWIDTH-1:0] mem_q    [P][FIFO_DEPTH];
  logic [DWIDTH-1:0] mem_d    [P][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [P];
  logic [AW-1:0]     wr_ptr_d [P];
  logic [AW-1:0]     rd_ptr_q [P];
  logic [AW-1:0]     rd_ptr_d [P];
  logic [AW:0]       cnt_q    [P];
  logic [AW:0]       cnt_d    [P];
  logic              ov_q     [P];
  logic              ov_d     [P];
  logic [DWIDTH-1:0] od_q     [P];
  logic [DWIDTH-1:0] od_d     [P];
  logic [PW-1:0]     lg_q     [P];
  logic [PW-1:0]     lg_d     [P];
  logic [7:0]        drop_q;
  logic [7:0]        drop_d;

  logic              in_vld  [P];
  logic [DWIDTH-1:0] in_dat  [P];
  logic              out_rdy [P];
  logic              full    [P];
  logic              empty   [P];
  logic [DWIDTH-1:0] head    [P];
  logic [PW-1:0]     route   [P];
  logic              push    [P];
  logic              pop     [P];
  logic              gnt_vld [P];
  logic [PW-1:0]     gnt_idx [P];
  logic [3:0]        drop_inc;

  // Input side: lane unpacking, FIFO status, head routing, push/drop decisions
  always_comb begin
    in_vld[0]  = gpu_in_valid;
    in_dat[0]  = gpu_in_data;
    out_rdy[0] = gpu_out_ready;
    for (int s = 0; s < NUM_SPINES; s++) begin
      in_vld[s+1]  = spine_in_valid[s];
      in_dat[s+1]  = spine_in_data[s*DWIDTH +: DWIDTH];
      out_rdy[s+1] = spine_out_ready[s];
    end
    drop_inc = '0;
    for (int p = 0; p < P; p++) begin
      full[p]  = (cnt_q[p] == (AW+1)'(FIFO_DEPTH));
      empty[p] = (cnt_q[p] == '0);
      head[p]  = mem_q[p][rd_ptr_q[p]];
      route[p] = (dest_of(head[p]) == SELF_ADDR) ? '0
               : PW'((int'(dest_of(head[p])) % NUM_SPINES) + 1);
      // Spine traffic not addressed to this router is consumed and counted, never stored
      push[p]  = in_vld[p] && !full[p] && ((p == 0) || (dest_of(in_dat[p]) == SELF_ADDR));
      if ((p != 0) && in_vld[p] && !full[p] && (dest_of(in_dat[p]) != SELF_ADDR))
        drop_inc = drop_inc + 4'd1;
    end
  end

  // Arbitration: per output, first requesting head after the last winner
  always_comb begin
    for (int o = 0; o < P; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = 1; k <= P; k++) begin
        if (!gnt_vld[o] && arb_enable && (!ov_q[o] || out_rdy[o]) &&
            !empty[rr_idx(lg_q[o], k)] && (route[rr_idx(lg_q[o], k)] == PW'(o))) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = PW'(rr_idx(lg_q[o], k));
        end
      end
    end
    for (int p = 0; p < P; p++) begin
      pop[p] = 1'b0;
      for (int o = 0; o < P; o++)
        if (gnt_vld[o] && (gnt_idx[o] == PW'(p))) pop[p] = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    od_d     = od_q;
    lg_d     = lg_q;
    drop_d   = sat_add8(drop_q, drop_inc);
    for (int p = 0; p < P; p++) begin
      if (push[p]) begin
        mem_d[p][wr_ptr_q[p]] = in_dat[p];
        wr_ptr_d[p]           = wr_ptr_q[p] + AW'(1);
      end
      if (pop[p]) rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
      cnt_d[p] = cnt_q[p] + {{AW{1'b0}}, push[p]} - {{AW{1'b0}}, pop[p]};
    end
    for (int o = 0; o < P; o++) begin
      if (gnt_vld[o]) begin
        ov_d[o] = 1'b1;
        od_d[o] = head[gnt_idx[o]];
        lg_d[o] = gnt_idx[o];
      end else if (ov_q[o] && out_rdy[o]) begin
        ov_d[o] = 1'b0;
      end
    end
  end

  // Register stage: control is reset, payload storage is not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < P; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
        ov_q[p]     <= 1'b0;
        lg_q[p]     <= PW'(NUM_SPINES);
      end
      drop_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      lg_q     <= lg_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    od_q  <= od_d;
  end

  always_comb begin
    gpu_in_ready    = !full[0];
    gpu_out_valid   = ov_q[0];
    gpu_out_data    = od_q[0];
    spine_in_ready  = '0;
    spine_out_valid = '0;
    spine_out_data  = '0;
    fifo_full       = '0;
    fifo_empty      = '0;
    for (int p = 0; p < P; p++) begin
      fifo_full[p]  = full[p];
      fifo_empty[p] = empty[p];
    end
    for (int s = 0; s < NUM_SPINES; s++) begin
      spine_in_ready[s]                    = !full[s+1];
      spine_out_valid[s]                   = ov_q[s+1];
      spine_out_data[s*DWIDTH +: DWIDTH]   = od_q[s+1];
    end
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_param_spine_router.sv
// Bench for param_spine_router: directed scenarios plus random traffic against a
// queue-based reference model of the router.
module tb_param_spine_router;
  localparam int         DW    = 16;
  localparam int         NS    = 4;
  localparam int         P     = NS + 1;
  localparam int         DEPTH = 4;
  localparam logic [5:0] SELF  = 6'h1B;

  logic             clk = 1'b0;
  logic             reset;
  logic             arb_enable;
  logic [DW-1:0]    gpu_in_data;
  logic             gpu_in_valid;
  logic             gpu_in_ready;
  logic [DW-1:0]    gpu_out_data;
  logic             gpu_out_valid;
  logic             gpu_out_ready;
  logic [NS*DW-1:0] spine_in_data;
  logic [NS-1:0]    spine_in_valid;
  logic [NS-1:0]    spine_in_ready;
  logic [NS*DW-1:0] spine_out_data;
  logic [NS-1:0]    spine_out_valid;
  logic [NS-1:0]    spine_out_ready;
  logic [NS:0]      fifo_full;
  logic [NS:0]      fifo_empty;
  logic [7:0]       drop_count;

  logic          i_vld [P];
  logic [DW-1:0] i_dat [P];
  logic          o_rdy [P];

  assign gpu_in_valid  = i_vld[0];
  assign gpu_in_data   = i_dat[0];
  assign gpu_out_ready = o_rdy[0];
  for (genvar s = 0; s < NS; s++) begin : g_lane
    assign spine_in_valid[s]        = i_vld[s+1];
    assign spine_in_data[s*DW +: DW] = i_dat[s+1];
    assign spine_out_ready[s]       = o_rdy[s+1];
  end

  wire [P-1:0]    all_rdy = {spine_in_ready, gpu_in_ready};
  wire [P-1:0]    all_ov  = {spine_out_valid, gpu_out_valid};
  wire [P*DW-1:0] all_od  = {spine_out_data, gpu_out_data};

  param_spine_router #(
    .DWIDTH(DW), .NUM_SPINES(NS), .FIFO_DEPTH(DEPTH), .ROUTER_ID(2'd3), .GROUP_ID(4'b0110)
  ) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .gpu_in_data(gpu_in_data), .gpu_in_valid(gpu_in_valid), .gpu_in_ready(gpu_in_ready),
    .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid), .gpu_out_ready(gpu_out_ready),
    .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid),
    .spine_in_ready(spine_in_ready), .spine_out_data(spine_out_data),
    .spine_out_valid(spine_out_valid), .spine_out_ready(spine_out_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef logic [DW-1:0] flit_q_t [$];
  flit_q_t       mq   [P];
  logic          mov  [P];
  logic [DW-1:0] mdat [P];
  int            mlg  [P];
  int            mdrop;
  int            checks = 0;
  int            failures = 0;

  function automatic int route_of(input logic [DW-1:0] f);
    if (f[DW-1 -: 6] == SELF) return 0;
    return 1 + (int'(f[DW-1 -: 6]) % NS);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      mq[p].delete();
      mov[p]  = 1'b0;
      mdat[p] = '0;
      mlg[p]  = NS;
    end
    mdrop = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < P; p++) begin
      chk($sformatf("in_ready[%0d]", p), 32'(all_rdy[p]), 32'(mq[p].size() < DEPTH));
      chk($sformatf("fifo_full[%0d]", p), 32'(fifo_full[p]), 32'(mq[p].size() == DEPTH));
      chk($sformatf("fifo_empty[%0d]", p), 32'(fifo_empty[p]), 32'(mq[p].size() == 0));
      chk($sformatf("out_valid[%0d]", p), 32'(all_ov[p]), 32'(mov[p]));
      if (mov[p]) chk($sformatf("out_data[%0d]", p), 32'(all_od[p*DW +: DW]), 32'(mdat[p]));
    end
    chk("drop_count", 32'(drop_count), 32'(mdrop));
  endtask

  // Check current state, advance the model by one clock with the applied inputs, clock the DUT.
  task automatic step();
    int gnt [P];
    bit rdy [P];
    compare_all();
    if (reset) begin
      model_reset();
    end else begin
      for (int p = 0; p < P; p++) rdy[p] = (mq[p].size() < DEPTH);
      for (int o = 0; o < P; o++) begin
        gnt[o] = -1;
        if (arb_enable && (!mov[o] || o_rdy[o])) begin
          for (int k = 1; k <= P; k++) begin
            int c;
            c = (mlg[o] + k) % P;
            if (mq[c].size() > 0 && route_of(mq[c][0]) == o) begin
              gnt[o] = c;
              break;
            end
          end
        end
      end
      for (int o = 0; o < P; o++) begin
        if (gnt[o] >= 0) begin
          mov[o]  = 1'b1;
          mdat[o] = mq[gnt[o]].pop_front();
          mlg[o]  = gnt[o];
        end else if (mov[o] && o_rdy[o]) begin
          mov[o] = 1'b0;
        end
      end
      for (int p = 0; p < P; p++) begin
        if (i_vld[p] && rdy[p]) begin
          if (p != 0 && i_dat[p][DW-1 -: 6] != SELF) begin
            if (mdrop < 255) mdrop++;
          end else begin
            mq[p].push_back(i_dat[p]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int p = 0; p < P; p++) begin
      i_vld[p] = 1'b0;
      i_dat[p] = '0;
    end
  endtask

  task automatic all_ready(input logic r);
    for (int p = 0; p < P; p++) o_rdy[p] = r;
  endtask

  function automatic logic [DW-1:0] rand_flit();
    logic [5:0] d;
    d = ($urandom_range(0, 3) < 2) ? SELF : 6'($urandom_range(0, 63));
    return {d, 10'($urandom)};
  endfunction

  task automatic rand_inputs(input bit arb_on);
    for (int p = 0; p < P; p++) begin
      i_vld[p] = ($urandom_range(0, 99) < 45);
      i_dat[p] = rand_flit();
      o_rdy[p] = ($urandom_range(0, 99) < 70);
    end
    arb_enable = arb_on && ($urandom_range(0, 99) < 85);
  endtask

  initial begin
    logic [DW-1:0] got [$];
    int idx;
    bit acc;

    reset = 1'b1;
    arb_enable = 1'b1;
    set_idle();
    all_ready(1'b1);
    model_reset();
    #1;
    step();
    step();
    reset = 1'b0;
    chk("rst_empty", 32'(fifo_empty), 32'h1F);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_ready", 32'(all_rdy), 32'h1F);

    // Local flit addressed to this router loops back after two edges
    i_vld[0] = 1'b1; i_dat[0] = 16'h6C05;
    step();
    set_idle();
    step();
    chk("t21_valid", 32'(gpu_out_valid), 32'h1);
    chk("t21_data", 32'(gpu_out_data), 32'h6C05);
    step();

    // Local flit to dest 0x01 leaves on spine lane 1 only
    i_vld[0] = 1'b1; i_dat[0] = 16'h04AA;
    step();
    set_idle();
    step();
    chk("t22_lanes", 32'(spine_out_valid), 32'h2);
    chk("t22_data", 32'(spine_out_data[DW +: DW]), 32'h04AA);
    chk("t22_gpu", 32'(gpu_out_valid), 32'h0);
    step();

    // Two spines contend for the local output
    i_vld[1] = 1'b1; i_dat[1] = 16'h6C11;
    i_vld[3] = 1'b1; i_dat[3] = 16'h6C22;
    step();
    set_idle();
    step();
    chk("t23_first_v", 32'(gpu_out_valid), 32'h1);
    chk("t23_first_d", 32'(gpu_out_data), 32'h6C11);
    step();
    chk("t23_second_v", 32'(gpu_out_valid), 32'h1);
    chk("t23_second_d", 32'(gpu_out_data), 32'h6C22);
    step();

    // Foreign-destination flits on spine 3 are all dropped
    i_vld[4] = 1'b1; i_dat[4] = 16'h0400;
    repeat (300) step();
    set_idle();
    step();
    chk("t24_drop", 32'(drop_count), 32'd255);
    chk("t24_no_out", 32'(all_ov), 32'h0);

    // Backpressure on spine lane 1, then release and drain in order
    o_rdy[2] = 1'b0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) begin
        chk("t25_hold_v", 32'(spine_out_valid[1]), 32'h1);
        chk("t25_hold_d", 32'(spine_out_data[DW +: DW]), 32'h0410);
        chk("t25_in_ready", 32'(gpu_in_ready), 32'h0);
        chk("t25_full", 32'(fifo_full[0]), 32'h1);
        o_rdy[2] = 1'b1;
      end
      i_vld[0] = (idx < 6);
      i_dat[0] = 16'h0410 + 16'(idx);
      acc = i_vld[0] && gpu_in_ready;
      if (spine_out_valid[1] && o_rdy[2]) got.push_back(spine_out_data[DW +: DW]);
      step();
      if (acc) idx++;
    end
    set_idle();
    chk("t25_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("t25_order%0d", i), 32'(got[i]), 32'(16'h0410 + 16'(i)));

    // Reset pulse with FIFOs partly filled
    all_ready(1'b0);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < P; p++) begin
        i_vld[p] = 1'b1;
        i_dat[p] = 16'h6C40 + 16'(p * 4 + c);
      end
      step();
    end
    set_idle();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t26_empty", 32'(fifo_empty), 32'h1F);
    chk("t26_full", 32'(fifo_full), 32'h0);
    chk("t26_valid", 32'(all_ov), 32'h0);
    chk("t26_ready", 32'(all_rdy), 32'h1F);
    step();
    step();
    reset = 1'b0;
    all_ready(1'b1);
    repeat (4) step();
    chk("t26_no_stale", 32'(all_ov), 32'h0);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rand_inputs(1'b1);
      step();
    end
    // Grants disabled: FIFOs fill, outputs drain
    for (int c = 0; c < 30; c++) begin
      rand_inputs(1'b0);
      step();
    end
    chk("arb_off_out", 32'(all_ov), 32'h0);
    set_idle();
    all_ready(1'b1);
    arb_enable = 1'b1;
    repeat (40) step();
    chk("final_empty", 32'(fifo_empty), 32'h1F);
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
